pi_delay_manager: RTL and testbench
===================================

PI_DELAY_MANAGER -- requirements
Module: pi_delay_manager

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16: cycles waited after delay-controller ready before declaring input path ready; legal range 1 to 1023.
REQ-002 SHALL have parameter TAP_WIDTH, default 5: width of the input-delay tap value.
REQ-003 SHALL have port iSystemClock, input, width 1: system clock; all logic is on the rising edge.
REQ-004 SHALL have port iReset, input, width 1: reset, asynchronous, active-high.
REQ-005 SHALL have port iPI_Reset, input, width 1: level-sensitive PHY-input reset request from the upstream input-reset sequencer.
REQ-006 SHALL have port iDelayCtrlRdy, input, width 1: delay-controller RDY; asynchronous to iSystemClock.
REQ-007 SHALL have port iTapReq, input, width 1: single-cycle tap-change request.
REQ-008 SHALL have port iTapTarget, input, width TAP_WIDTH: requested tap value; sampled only with iTapReq.
REQ-009 SHALL have port oIDelayRst, output, width 1: reset to the input-delay primitives.
REQ-010 SHALL have port oTapCE, output, width 1: tap clock-enable pulse.
REQ-011 SHALL have port oTapINC, output, width 1: tap direction (1 = increment, 0 = decrement).
REQ-012 SHALL have port oCurrentTap, output, width TAP_WIDTH: tracked tap value.
REQ-013 SHALL have port oTapBusy, output, width 1: tap stepping is in progress.
REQ-014 SHALL have port oPIDelayReady, output, width 1: input delay path is usable; this feeds the upstream sequencer's iPIDelayReady.

Function
REQ-015 SHALL pass iDelayCtrlRdy through a two-flop synchronizer; all uses of it refer to the synchronized signal (wRdy).
REQ-016 SHALL implement a one-hot FSM with states RESET, HOLD, WAITRDY, SETTLE, READY and STEP.
REQ-017 SHALL, in every state, take iPI_Reset=1 as highest priority and move to HOLD.
REQ-018 SHALL make RESET go to WAITRDY unconditionally.
REQ-019 SHALL, in HOLD: drive oIDelayRst=1, clear oCurrentTap to 0, and stay while iPI_Reset=1; go to WAITRDY on the first cycle iPI_Reset=0.
REQ-020 SHALL, in WAITRDY: go to SETTLE when wRdy=1, with the settle counter loaded to 0.
REQ-021 SHALL, in SETTLE: increment the 10-bit counter each cycle and go to READY when the counter equals SETTLE_CYCLES-1.
REQ-022 SHALL, in READY: on iTapReq=1 with iTapTarget≠oCurrentTap, latch the target and go to STEP; on iTapReq=1 with iTapTarget=oCurrentTap, ignore the request (no busy, no CE).
REQ-023 SHALL, in STEP, run alternating CE and gap cycles: on a CE cycle, oTapCE=1 for one cycle and oCurrentTap moves ±1 in the same cycle; the next cycle is a gap with oTapCE=0.
REQ-024 SHALL, in STEP, drive oTapINC=1 when target>current, else 0, stable during CE and gap cycles; return to READY on the gap cycle after current equals target.
REQ-025 SHALL keep oCurrentTap from wrapping; because the target is bounded, at most (2^TAP_WIDTH)-1 steps occur.
REQ-026 SHALL ignore iTapReq in any state other than READY; no queuing.
REQ-027 SHALL, if wRdy falls in SETTLE, READY or STEP: go to WAITRDY, abandon any step in progress, keep oCurrentTap, and drop oTapBusy.
REQ-028 SHALL register all outputs, decoded from the next state, so each output changes in the same cycle the FSM enters the corresponding state.
REQ-029 SHALL assert oPIDelayReady only in READY and STEP, and oTapBusy only in STEP.
REQ-030 SHALL give a latency from iPI_Reset falling (wRdy already high) to oPIDelayReady=1 of 1 + SETTLE_CYCLES cycles; if wRdy must re-synchronize, add 2 cycles.

Reset
REQ-031 SHALL, on iReset, set the FSM to RESET and set oIDelayRst=1, oTapCE=0, oTapINC=0, oCurrentTap=0, oTapBusy=0, oPIDelayReady=0, counters=0 and synchronizer=0, asynchronously.
REQ-032 SHALL treat iReset during STEP like power-on: the tap count is lost, and recovery requires an iPI_Reset cycle or a new request after READY.

Verification
REQ-033 SHALL cover power-on: iReset released, iDelayCtrlRdy=1 → oPIDelayReady=1 exactly 1 + 2 + 16 cycles later (default SETTLE_CYCLES); oIDelayRst=0 after RESET.
REQ-034 SHALL cover HOLD: iPI_Reset high for 10 cycles while READY with tap=7 → oPIDelayReady=0 next cycle, oIDelayRst=1 for 10 cycles, oCurrentTap=0, ready 17 cycles after release.
REQ-035 SHALL cover step up: tap=3, iTapReq with target=6 → exactly 3 oTapCE pulses 2 cycles apart, oTapINC=1, oCurrentTap=6, oTapBusy high 6 cycles.
REQ-036 SHALL cover step down to boundary: tap=31, target=0 → 31 CE pulses, oTapINC=0, final tap 0, no wrap; and a same-value request → no CE, no busy.
REQ-037 SHALL cover loss of ready: wRdy drops mid-STEP at tap=4 of 0→9 → CE stops, oCurrentTap holds 4, oPIDelayReady=0, re-ready 16 cycles after wRdy returns.
REQ-038 SHALL cover simultaneous events: iTapReq and iPI_Reset asserted in the same cycle → HOLD wins, no CE, oCurrentTap=0.

Source files
------------

// File: rtl/pi_delay_manager.sv
// Input-delay path manager: waits for the delay controller, settles, then walks
// the input-delay tap one CE pulse at a time toward a requested value.
//
// state   | meaning
// --------+------------------------------------------------------------
// RESET   | post-reset single cycle, delay primitives held in reset
// HOLD    | PHY-input reset requested, delay primitives held, tap cleared
// WAITRDY | waiting for synchronized delay-controller ready
// SETTLE  | ready seen, counting out the settle interval
// READY   | input path usable, accepting tap requests
// STEP    | alternating CE / gap cycles toward the latched target
module pi_delay_manager #(
    parameter int SETTLE_CYCLES = 16,
    parameter int TAP_WIDTH     = 5
) (
    input  logic                 iSystemClock,
    input  logic                 iReset,
    input  logic                 iPI_Reset,
    input  logic                 iDelayCtrlRdy,
    input  logic                 iTapReq,
    input  logic [TAP_WIDTH-1:0] iTapTarget,
    output logic                 oIDelayRst,
    output logic                 oTapCE,
    output logic                 oTapINC,
    output logic [TAP_WIDTH-1:0] oCurrentTap,
    output logic                 oTapBusy,
    output logic                 oPIDelayReady
);

    typedef enum logic [5:0] {
        S_RESET   = 6'b000001,
        S_HOLD    = 6'b000010,
        S_WAITRDY = 6'b000100,
        S_SETTLE  = 6'b001000,
        S_READY   = 6'b010000,
        S_STEP    = 6'b100000
    } state_t;

    localparam logic [9:0] SETTLE_LAST = 10'(SETTLE_CYCLES - 1);

    state_t                 state_q, state_d;
    logic                   rdy_meta_q, rdy_meta_d;
    logic                   rdy_sync_q, rdy_sync_d;
    logic [9:0]             settle_cnt_q, settle_cnt_d;
    logic [9:0]             settle_inc;
    logic [TAP_WIDTH-1:0]   target_q, target_d;
    logic [TAP_WIDTH-1:0]   cur_tap_q, cur_tap_d;
    logic                   tap_ce_q, tap_ce_d;
    logic                   tap_inc_q, tap_inc_d;
    logic                   idelay_rst_q, idelay_rst_d;
    logic                   tap_busy_q, tap_busy_d;
    logic                   pi_ready_q, pi_ready_d;

    assign settle_inc = settle_cnt_q + 10'd1;

    always_comb begin
        // Synchronizer stays flushed during RESET so power-on always sees a full resync.
        rdy_meta_d   = (state_q == S_RESET) ? 1'b0 : iDelayCtrlRdy;
        rdy_sync_d   = (state_q == S_RESET) ? 1'b0 : rdy_meta_q;
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        target_d     = target_q;
        cur_tap_d    = cur_tap_q;
        tap_ce_d     = 1'b0;
        tap_inc_d    = tap_inc_q;

        if (iPI_Reset) begin
            state_d   = S_HOLD;
            cur_tap_d = '0;
        end else begin
            case (state_q)
                S_RESET: state_d = S_WAITRDY;
                S_HOLD:  state_d = S_WAITRDY;
                S_WAITRDY: begin
                    if (rdy_sync_q) begin
                        settle_cnt_d = '0;
                        state_d      = (SETTLE_CYCLES == 1) ? S_READY : S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (!rdy_sync_q) begin
                        state_d = S_WAITRDY;
                    end else begin
                        // The WAITRDY cycle counts toward the settle interval.
                        settle_cnt_d = settle_inc;
                        if (settle_inc == SETTLE_LAST) state_d = S_READY;
                    end
                end
                S_READY: begin
                    if (!rdy_sync_q) begin
                        state_d = S_WAITRDY;
                    end else if (iTapReq && (iTapTarget != cur_tap_q)) begin
                        state_d   = S_STEP;
                        target_d  = iTapTarget;
                        tap_inc_d = (iTapTarget > cur_tap_q);
                        tap_ce_d  = 1'b1;
                        cur_tap_d = (iTapTarget > cur_tap_q) ? cur_tap_q + TAP_WIDTH'(1)
                                                             : cur_tap_q - TAP_WIDTH'(1);
                    end
                end
                S_STEP: begin
                    if (!rdy_sync_q) begin
                        state_d = S_WAITRDY;
                    end else if (!tap_ce_q) begin
                        if (cur_tap_q == target_q) begin
                            state_d = S_READY;
                        end else begin
                            tap_ce_d  = 1'b1;
                            cur_tap_d = tap_inc_q ? cur_tap_q + TAP_WIDTH'(1)
                                                  : cur_tap_q - TAP_WIDTH'(1);
                        end
                    end
                end
                default: state_d = S_RESET;
            endcase
        end

        idelay_rst_d = (state_d == S_RESET) || (state_d == S_HOLD);
        tap_busy_d   = (state_d == S_STEP);
        pi_ready_d   = (state_d == S_READY) || (state_d == S_STEP);
    end

    always_ff @(posedge iSystemClock or posedge iReset) begin
        if (iReset) begin
            state_q      <= S_RESET;
            rdy_meta_q   <= 1'b0;
            rdy_sync_q   <= 1'b0;
            settle_cnt_q <= '0;
            target_q     <= '0;
            cur_tap_q    <= '0;
            tap_ce_q     <= 1'b0;
            tap_inc_q    <= 1'b0;
            idelay_rst_q <= 1'b1;
            tap_busy_q   <= 1'b0;
            pi_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rdy_meta_q   <= rdy_meta_d;
            rdy_sync_q   <= rdy_sync_d;
            settle_cnt_q <= settle_cnt_d;
            target_q     <= target_d;
            cur_tap_q    <= cur_tap_d;
            tap_ce_q     <= tap_ce_d;
            tap_inc_q    <= tap_inc_d;
            idelay_rst_q <= idelay_rst_d;
            tap_busy_q   <= tap_busy_d;
            pi_ready_q   <= pi_ready_d;
        end
    end

    assign oIDelayRst    = idelay_rst_q;
    assign oTapCE        = tap_ce_q;
    assign oTapINC       = tap_inc_q;
    assign oCurrentTap   = cur_tap_q;
    assign oTapBusy      = tap_busy_q;
    assign oPIDelayReady = pi_ready_q;

endmodule

// File: tb/tb_pi_delay_manager.sv
// Directed bench for pi_delay_manager: expected CE pulses are queued when a tap
// request is driven and consumed by a monitor as the DUT pulses oTapCE.
module tb_pi_delay_manager;

    logic       clk = 1'b0;
    logic       rst;
    logic       pi_rst;
    logic       rdy;
    logic       req;
    logic [4:0] tgt;
    logic       idelay_rst, tap_ce, tap_inc, tap_busy, pi_ready;
    logic [4:0] cur_tap;

    always #5 clk = ~clk;

    pi_delay_manager #(.SETTLE_CYCLES(16), .TAP_WIDTH(5)) dut (
        .iSystemClock (clk),
        .iReset       (rst),
        .iPI_Reset    (pi_rst),
        .iDelayCtrlRdy(rdy),
        .iTapReq      (req),
        .iTapTarget   (tgt),
        .oIDelayRst   (idelay_rst),
        .oTapCE       (tap_ce),
        .oTapINC      (tap_inc),
        .oCurrentTap  (cur_tap),
        .oTapBusy     (tap_busy),
        .oPIDelayReady(pi_ready)
    );

    typedef struct {
        logic [4:0] tap;
        logic       inc;
        logic       first;
    } ce_exp_t;

    ce_exp_t sb[$];
    ce_exp_t mon_e;
    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int last_ce   = 0;
    int model_tap = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (tap_ce === 1'b1) begin
            check("ce_pending", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("ce_tap", 32'(cur_tap), 32'(mon_e.tap));
                check("ce_inc", 32'(tap_inc), 32'(mon_e.inc));
                if (!mon_e.first) check("ce_spacing", 32'(cyc - last_ce), 2);
            end
            last_ce = cyc;
        end
    end

    task automatic wait_ready(input int expected, input string tag);
        int n;
        n = 0;
        while (!pi_ready && n < 300) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'(expected));
    endtask

    task automatic push_steps(input int from, input int to, output int steps);
        ce_exp_t e;
        int t;
        int up;
        up = (to > from) ? 1 : 0;
        t = from;
        steps = 0;
        while (t != to) begin
            t = up ? t + 1 : t - 1;
            e.tap   = t[4:0];
            e.inc   = up[0];
            e.first = (steps == 0);
            sb.push_back(e);
            steps++;
        end
    endtask

    task automatic do_step(input int target, input string tag);
        int steps;
        int n;
        push_steps(model_tap, target, steps);
        tgt = target[4:0];
        req = 1'b1;
        tick();
        req = 1'b0;
        n = 0;
        while (tap_busy && n < 200) begin
            n++;
            tick();
        end
        check({tag, "_busy_cycles"}, 32'(n), 32'(2 * steps));
        check({tag, "_final_tap"}, 32'(cur_tap), 32'(target));
        check({tag, "_sb_drained"}, 32'(sb.size()), 0);
        check({tag, "_ready"}, 32'(pi_ready), 1);
        model_tap = target;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rcnt;

        rst    = 1'b1;
        pi_rst = 1'b0;
        rdy    = 1'b1;
        req    = 1'b0;
        tgt    = '0;
        repeat (3) @(negedge clk);
        check("rst_idelay_rst", 32'(idelay_rst), 1);
        check("rst_tap_ce", 32'(tap_ce), 0);
        check("rst_tap_inc", 32'(tap_inc), 0);
        check("rst_cur_tap", 32'(cur_tap), 0);
        check("rst_busy", 32'(tap_busy), 0);
        check("rst_ready", 32'(pi_ready), 0);

        // Power-on: RESET cycle + two-stage resync + 16 settle cycles
        rst = 1'b0;
        tick();
        n = 1;
        check("por_idelay_rst_drop", 32'(idelay_rst), 0);
        while (!pi_ready && n < 300) begin
            tick();
            n++;
        end
        check("por_ready_latency", 32'(n), 19);

        do_step(7, "up_0_7");

        // HOLD for 10 cycles with tap at 7
        pi_rst = 1'b1;
        rcnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (idelay_rst) rcnt++;
            if (i == 0) begin
                check("hold_ready_drop", 32'(pi_ready), 0);
                check("hold_tap_clear", 32'(cur_tap), 0);
            end
        end
        check("hold_idelay_rst_cycles", 32'(rcnt), 10);
        pi_rst = 1'b0;
        model_tap = 0;
        wait_ready(17, "hold_ready_latency");
        check("hold_idelay_rst_release", 32'(idelay_rst), 0);

        do_step(3, "up_0_3");
        do_step(6, "up_3_6");
        do_step(31, "up_6_31");
        do_step(0, "down_31_0");
        do_step(0, "same_0_0");
        check("same_no_ce", 32'(tap_ce), 0);
        do_step(5, "up_0_5");

        // Tap request and PHY-input reset in the same cycle
        pi_rst = 1'b1;
        tgt    = 5'd12;
        req    = 1'b1;
        tick();
        req    = 1'b0;
        pi_rst = 1'b0;
        check("simul_busy", 32'(tap_busy), 0);
        check("simul_ce", 32'(tap_ce), 0);
        check("simul_tap", 32'(cur_tap), 0);
        check("simul_idelay_rst", 32'(idelay_rst), 1);
        model_tap = 0;
        wait_ready(17, "simul_ready_latency");

        // Ready lost mid-step of 0 -> 9; the CE already in the synchronizer shadow lands tap on 4
        push_steps(0, 4, n);
        tgt = 5'd9;
        req = 1'b1;
        tick();
        req = 1'b0;
        n = 0;
        while (!(tap_ce && cur_tap == 5'd3) && n < 50) begin
            tick();
            n++;
        end
        check("drop_reach_tap3", 32'(cur_tap), 3);
        rdy = 1'b0;
        repeat (3) tick();
        check("drop_ready", 32'(pi_ready), 0);
        check("drop_busy", 32'(tap_busy), 0);
        check("drop_tap_hold", 32'(cur_tap), 4);
        tgt = 5'd20;
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (4) tick();
        check("notready_req_busy", 32'(tap_busy), 0);
        check("notready_req_tap", 32'(cur_tap), 4);
        check("drop_sb_drained", 32'(sb.size()), 0);
        rdy = 1'b1;
        wait_ready(18, "rerdy_latency_incl_sync");
        check("rerdy_tap", 32'(cur_tap), 4);
        model_tap = 4;
        do_step(2, "down_4_2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
